dsp_mac_sequencer: RTL and testbench

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

---
 rtl/dsp_mac_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Purpose : sequences a multiply-accumulate job of `len` operand pairs through
//           an external DSP slice, waits out the slice pipeline and captures the sum.
// Latency : done is high N+PIPE_LAT+2 cycles after the start edge (N terms, no bubbles).
// Backpressure: in_ready is high only while ISSUE is accepting terms; a bubble
//           on in_valid holds the accumulator (opmode 8'h08) and stretches the job.
//
// Ports:
//   CLK, RST            single rising-edge clock, synchronous active-high reset
//   start, len          begin a job of `len` products (len sampled with start, in IDLE only)
//   a_in, b_in          operand pair, handshaken by in_valid / in_ready
//   dsp_a, dsp_b        registered operands to the slice
//   dsp_opmode, dsp_ce  slice control (8'h01 first term, 8'h09 later terms, 8'h08 hold)
//   dsp_p               slice P output
//   busy, done, result  job status, one-cycle completion pulse, captured 48-bit sum
//
// Build option: define MAC_SEQ_ABORT_EN to add the `abort` input, which drops
// an in-flight job back to IDLE without done and without touching result.

module dsp_mac_sequencer #(
   parameter int WIDTH    = 18,
   parameter int LEN_W    = 8,
   parameter int PIPE_LAT = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef MAC_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic [WIDTH-1:0] dsp_a,
   output logic [WIDTH-1:0] dsp_b,
   output logic [7:0]       dsp_opmode,
   output logic             dsp_ce,
   input  logic [47:0]      dsp_p,
   output logic             busy,
   output logic             done,
   output logic [47:0]      result
);

   localparam int DW = $clog2(PIPE_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [LEN_W-1:0] r_remaining;
   logic [DW-1:0]    r_drain;
   logic             r_first;
   logic [WIDTH-1:0] r_dsp_a;
   logic [WIDTH-1:0] r_dsp_b;
   logic [47:0]      r_result;
   logic             w_abort;
   logic             w_accept;

`ifdef MAC_SEQ_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_accept = in_valid & in_ready;

   // Next state and all control outputs are decoded from the current state.
   // The slice registers its opmode one stage ahead of the operands, so the
   // opmode driven in the accepting cycle pairs with the operands registered
   // on that same edge.
   always_comb begin
      w_next     = r_state;
      in_ready   = 1'b0;
      dsp_ce     = 1'b0;
      dsp_opmode = 8'h00;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (len != '0) ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: begin
            busy = 1'b1;
            if (w_abort) begin
               w_next = S_IDLE;
            end else begin
               in_ready = 1'b1;
               dsp_ce   = 1'b1;
               if (in_valid) begin
                  dsp_opmode = r_first ? 8'h01 : 8'h09;
                  if (r_remaining == LEN_W'(1)) begin
                     w_next = S_DRAIN;
                  end
               end else begin
                  dsp_opmode = 8'h08;
               end
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (w_abort) begin
               w_next = S_IDLE;
            end else begin
               dsp_ce     = 1'b1;
               dsp_opmode = 8'h08;
               if (r_drain == '0) begin
                  w_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_drain     <= '0;
         r_first     <= 1'b0;
         r_dsp_a     <= '0;
         r_dsp_b     <= '0;
         r_result    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     r_remaining <= len;
                     r_first     <= 1'b1;
                  end else begin
                     r_result <= '0;
                  end
               end
            end
            S_ISSUE: begin
               if (w_accept) begin
                  r_dsp_a     <= a_in;
                  r_dsp_b     <= b_in;
                  r_first     <= 1'b0;
                  r_remaining <= r_remaining - LEN_W'(1);
                  if (r_remaining == LEN_W'(1)) begin
                     r_drain <= DW'(PIPE_LAT);
                  end
               end
            end
            S_DRAIN: begin
               // Counter reaches zero exactly when the last product is on dsp_p.
               if (!w_abort) begin
                  if (r_drain == '0) begin
                     r_result <= dsp_p;
                  end else begin
                     r_drain <= r_drain - DW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign dsp_a  = r_dsp_a;
   assign dsp_b  = r_dsp_b;
   assign result = r_result;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP slice drives dsp_p, jobs are
// checked against plain sum-of-products arithmetic and cycle-count rules.
// Cycle index j below = the rising edge (counted from the start edge) that samples the cycle.

module tb_dsp_mac_sequencer;

   localparam int W  = 18;
   localparam int LW = 8;
   localparam int PL = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          start;
   logic [LW-1:0] len;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  dsp_a;
   logic [W-1:0]  dsp_b;
   logic [7:0]    dsp_opmode;
   logic          dsp_ce;
   logic [47:0]   dsp_p;
   logic          busy;
   logic          done;
   logic [47:0]   result;
`ifdef MAC_SEQ_ABORT_EN
   logic          abort;
`endif

   dsp_mac_sequencer #(.WIDTH(W), .LEN_W(LW), .PIPE_LAT(PL)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start),
      .len        (len),
      .a_in       (a_in),
      .b_in       (b_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
`ifdef MAC_SEQ_ABORT_EN
      .abort      (abort),
`endif
      .dsp_a      (dsp_a),
      .dsp_b      (dsp_b),
      .dsp_opmode (dsp_opmode),
      .dsp_ce     (dsp_ce),
      .dsp_p      (dsp_p),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   always #5 CLK = ~CLK;

   // Slice model: opmode register stage, then accumulator, then PL-1 output
   // stages, so the last product appears on dsp_p PL edges after its operands.
   logic [7:0]  sl_opm;
   logic [47:0] sl_p [PL];

   always @(posedge CLK) begin
      if (RST) begin
         sl_opm <= 8'h00;
         for (int i = 0; i < PL; i++) sl_p[i] <= '0;
      end else if (dsp_ce) begin
         sl_opm  <= dsp_opmode;
         sl_p[0] <= (sl_opm[0] ? 48'(dsp_a) * 48'(dsp_b) : 48'd0) +
                    (sl_opm[3] ? sl_p[0] : 48'd0);
         for (int i = 1; i < PL; i++) sl_p[i] <= sl_p[i-1];
      end
   end
   assign dsp_p = sl_p[PL-1];

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] va [16];
   logic [W-1:0] vb [16];
   int           vg [16];   // bubbles inserted before term i (i >= 1)

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [47:0] ref_sum(input int n);
      logic [47:0] s = '0;
      for (int i = 0; i < n; i++) s = s + 48'(va[i]) * 48'(vb[i]);
      return s;
   endfunction

   function automatic int ref_done(input int n);
      int b = 0;
      if (n == 0) return 1;
      for (int i = 1; i < n; i++) b += vg[i];
      return n + PL + 2 + b;
   endfunction

   // Runs one job from va/vb/vg; mid_start pulses start(len=9) in the second
   // ISSUE cycle and keeps offering junk terms after the last real one.
   task automatic run_job(input int n, input bit mid_start,
                          output int done_at, output int done_cnt, output int acc_cnt,
                          output bit ce_seen, output int opm_err, output int busy_at_done);
      int j, idx, wait_cnt, limit;
      logic [7:0] exp_op;
      done_at = -1; done_cnt = 0; acc_cnt = 0; ce_seen = 1'b0; opm_err = 0; busy_at_done = 0;
      idx = 0; wait_cnt = 0; limit = n * 4 + PL + 12;
      @(negedge CLK);
      start = 1'b1; len = LW'(n); in_valid = 1'b0;
      @(negedge CLK);
      start = 1'b0; len = '0;
      for (j = 1; j < limit; j++) begin
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = j;
            if (busy) busy_at_done++;
         end
         a_in = W'($urandom); b_in = W'($urandom);
         in_valid = 1'b0;
         if (idx < n) begin
            if (wait_cnt > 0) wait_cnt--;
            else begin in_valid = 1'b1; a_in = va[idx]; b_in = vb[idx]; end
         end else if (mid_start) begin
            in_valid = 1'b1; a_in = W'(1); b_in = W'(1);
         end
         if (mid_start && j == 2) begin start = 1'b1; len = LW'(9); end
         else begin start = 1'b0; len = '0; end
         #1;
         if (dsp_ce) ce_seen = 1'b1;
         if (in_ready) begin
            exp_op = in_valid ? ((acc_cnt == 0) ? 8'h01 : 8'h09) : 8'h08;
            if (dsp_opmode !== exp_op) opm_err++;
         end
         if (in_valid && in_ready) begin
            acc_cnt++;
            if (idx < n) begin
               idx++;
               if (idx < n) wait_cnt = vg[idx];
            end
         end
         @(negedge CLK);
      end
      in_valid = 1'b0; start = 1'b0; len = '0;
   endtask

   typedef struct {
      int                  n;
      int                  gap;
      logic [2:0][W-1:0]   a;
      logic [2:0][W-1:0]   b;
      logic [47:0]         exp_res;
      int                  exp_done;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int d_at, d_cnt, acc, oerr, bsy, n, dcount;
      bit ce_s;
      logic [47:0] held;

      RST = 1'b1; start = 1'b0; len = '0; a_in = '0; b_in = '0; in_valid = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      // (a[2],a[1],a[0]) ordering in the concatenations below
      tbl[0] = '{n:3, gap:0, a:{18'd6, 18'd4, 18'd2}, b:{18'd7, 18'd5, 18'd3},
                 exp_res:48'd68, exp_done:3+PL+2};
      tbl[1] = '{n:0, gap:0, a:'0, b:'0, exp_res:48'd0, exp_done:1};
      tbl[2] = '{n:2, gap:3, a:{18'd0, 18'd7, 18'd5}, b:{18'd0, 18'd8, 18'd6},
                 exp_res:48'd86, exp_done:2+PL+2+3};
      tbl[3] = '{n:1, gap:0, a:{18'd0, 18'd0, 18'd1000}, b:{18'd0, 18'd0, 18'd1000},
                 exp_res:48'd1000000, exp_done:1+PL+2};
      tbl[4] = '{n:3, gap:0, a:{18'h3FFFF, 18'h3FFFF, 18'h3FFFF}, b:{18'h3FFFF, 18'h3FFFF, 18'h3FFFF},
                 exp_res:48'd206156857347, exp_done:3+PL+2};
      tbl[5] = '{n:3, gap:1, a:{18'd5, 18'd3, 18'd1}, b:{18'd6, 18'd4, 18'd2},
                 exp_res:48'd44, exp_done:3+PL+2+2};

      repeat (3) @(negedge CLK);
      chk("reset busy",     64'(busy),       64'd0);
      chk("reset done",     64'(done),       64'd0);
      chk("reset in_ready", 64'(in_ready),   64'd0);
      chk("reset dsp_ce",   64'(dsp_ce),     64'd0);
      chk("reset opmode",   64'(dsp_opmode), 64'd0);
      chk("reset dsp_a",    64'(dsp_a),      64'd0);
      chk("reset result",   64'(result),     64'd0);
      RST = 1'b0;

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 3; i++) begin
            va[i] = tbl[t].a[i]; vb[i] = tbl[t].b[i]; vg[i] = (i == 0) ? 0 : tbl[t].gap;
         end
         run_job(tbl[t].n, 1'b0, d_at, d_cnt, acc, ce_s, oerr, bsy);
         chk($sformatf("tbl%0d done cycle", t), 64'(d_at), 64'(tbl[t].exp_done));
         chk($sformatf("tbl%0d done pulses", t), 64'(d_cnt), 64'd1);
         chk($sformatf("tbl%0d result", t), 64'(result), 64'(tbl[t].exp_res));
         chk($sformatf("tbl%0d terms", t), 64'(acc), 64'(tbl[t].n));
         chk($sformatf("tbl%0d opmode errs", t), 64'(oerr), 64'd0);
         chk($sformatf("tbl%0d busy at done", t), 64'(bsy), 64'd0);
         if (tbl[t].n == 0) chk("len0 dsp_ce seen", 64'(ce_s), 64'd0);
      end

      // start with len=9 while a len=2 job is issuing must be ignored
      va[0] = 18'd11; vb[0] = 18'd12; va[1] = 18'd13; vb[1] = 18'd14; vg[1] = 0;
      run_job(2, 1'b1, d_at, d_cnt, acc, ce_s, oerr, bsy);
      chk("midstart terms",  64'(acc),    64'd2);
      chk("midstart done",   64'(d_at),   64'(2 + PL + 2));
      chk("midstart pulses", 64'(d_cnt),  64'd1);
      chk("midstart result", 64'(result), 64'd314);

      for (int r = 0; r < 10; r++) begin
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            va[i] = W'($urandom); vb[i] = W'($urandom);
            vg[i] = (i == 0) ? 0 : $urandom_range(0, 2);
         end
         run_job(n, 1'b0, d_at, d_cnt, acc, ce_s, oerr, bsy);
         chk($sformatf("rnd%0d done cycle", r), 64'(d_at), 64'(ref_done(n)));
         chk($sformatf("rnd%0d result", r), 64'(result), 64'(ref_sum(n)));
         chk($sformatf("rnd%0d opmode errs", r), 64'(oerr), 64'd0);
      end

      // reset while draining a len=4 job
      @(negedge CLK); start = 1'b1; len = LW'(4);
      @(negedge CLK); start = 1'b0; len = '0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a_in = W'(i + 1); b_in = W'(i + 2);
         @(negedge CLK);
      end
      in_valid = 1'b0;
      chk("drain busy", 64'(busy), 64'd1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("rst drain busy",     64'(busy),       64'd0);
      chk("rst drain done",     64'(done),       64'd0);
      chk("rst drain in_ready", 64'(in_ready),   64'd0);
      chk("rst drain dsp_ce",   64'(dsp_ce),     64'd0);
      chk("rst drain opmode",   64'(dsp_opmode), 64'd0);
      chk("rst drain dsp_a",    64'(dsp_a),      64'd0);
      chk("rst drain dsp_b",    64'(dsp_b),      64'd0);
      chk("rst drain result",   64'(result),     64'd0);
      dcount = 0;
      repeat (12) begin @(negedge CLK); if (done) dcount++; end
      chk("rst drain no done", 64'(dcount), 64'd0);

`ifdef MAC_SEQ_ABORT_EN
      va[0] = 18'd3; vb[0] = 18'd5; va[1] = 18'd4; vb[1] = 18'd6; vg[1] = 0;
      run_job(2, 1'b0, d_at, d_cnt, acc, ce_s, oerr, bsy);
      held = 48'd39;
      chk("pre-abort result", 64'(result), 64'(held));
      @(negedge CLK); start = 1'b1; len = LW'(5);
      @(negedge CLK); start = 1'b0; len = '0; in_valid = 1'b1; a_in = 18'd7; b_in = 18'd7;
      @(negedge CLK); in_valid = 1'b0; abort = 1'b1;
      #1;
      chk("abort opmode", 64'(dsp_opmode), 64'd0);
      chk("abort dsp_ce", 64'(dsp_ce),     64'd0);
      @(negedge CLK); abort = 1'b0;
      chk("abort busy",     64'(busy),     64'd0);
      chk("abort in_ready", 64'(in_ready), 64'd0);
      dcount = 0;
      repeat (12) begin @(negedge CLK); if (done) dcount++; end
      chk("abort no done", 64'(dcount), 64'd0);
      chk("abort result",  64'(result), 64'(held));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
